jk_counter_reg: RTL and testbench

Parametrised WIDTH-bit register bank of JK cells with a selectable operating mode: per-bit JK control, parallel load, or synchronous up/down counting built from JK toggle equations. It generalises the single-bit JK flip-flop to a multi-bit sequential building block for counters, status registers and event latches in the digital-logic exercise set. All outputs are registered, with a single-cycle update latency.

---
 rtl/jk_pkg.sv | 17 +
 rtl/jk_cell.sv | 34 +++
 rtl/jk_counter_reg.sv | 114 +++++++++++
 tb/tb_jk_counter_reg.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/jk_pkg.sv
// rtl/jk_pkg.sv - shared mode and JK action encodings for jk_counter_reg
package jk_pkg;

  localparam logic [1:0] MODE_JK   = 2'd0;
  localparam logic [1:0] MODE_LOAD = 2'd1;
  localparam logic [1:0] MODE_UP   = 2'd2;
  localparam logic [1:0] MODE_DOWN = 2'd3;

  // Action of one cell, indexed by the {j,k} pair.
  typedef enum logic [1:0] {
    JK_HOLD = 2'b00,
    JK_CLR  = 2'b01,
    JK_SET  = 2'b10,
    JK_TGL  = 2'b11
  } jk_act_e;

endpackage

// File: rtl/jk_cell.sv
// rtl/jk_cell.sv - single JK flip-flop with enable and async active-high reset
module jk_cell
  import jk_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic rst_val,
  input  logic en,
  input  logic j,
  input  logic k,
  output logic q
);

  logic r_q;
  jk_act_e w_act;

  assign w_act = jk_act_e'({j, k});
  assign q     = r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= rst_val;
    end else if (en) begin
      case (w_act)
        JK_HOLD: r_q <= r_q;
        JK_CLR:  r_q <= 1'b0;
        JK_SET:  r_q <= 1'b1;
        JK_TGL:  r_q <= ~r_q;
        default: r_q <= r_q;
      endcase
    end
  end

endmodule

// File: rtl/jk_counter_reg.sv
// rtl/jk_counter_reg.sv - WIDTH-bit JK register bank with JK/LOAD/UP/DOWN modes
// Optional saturating count build: define JK_COUNTER_REG_SAT_EN.
module jk_counter_reg
  import jk_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             chg
);

  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_j;
  logic [WIDTH-1:0] w_k;
  logic [WIDTH-1:0] w_ones_below;
  logic [WIDTH-1:0] w_zeros_below;
  logic [WIDTH-1:0] w_q_next;
  logic             w_at_limit;
  logic             r_tc;
  logic             r_chg;

  // Carry (UP) and borrow (DOWN) chains: bit i toggles when all lower bits are 1 / 0.
  always_comb begin
    logic v_ones;
    logic v_zeros;
    v_ones        = 1'b1;
    v_zeros       = 1'b1;
    w_ones_below  = '0;
    w_zeros_below = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_ones_below[i]  = v_ones;
      w_zeros_below[i] = v_zeros;
      v_ones           = v_ones & w_q[i];
      v_zeros          = v_zeros & ~w_q[i];
    end
  end

  assign w_at_limit = ((mode == MODE_UP) && (&w_q)) || ((mode == MODE_DOWN) && !(|w_q));

  always_comb begin
    w_j = '0;
    w_k = '0;
    case (mode)
      MODE_JK: begin
        w_j = j;
        w_k = k;
      end
      MODE_LOAD: begin
        w_j = d;
        w_k = ~d;
      end
      MODE_UP: begin
        w_j = w_ones_below;
        w_k = w_ones_below;
      end
      MODE_DOWN: begin
        w_j = w_zeros_below;
        w_k = w_zeros_below;
      end
      default: begin
        w_j = '0;
        w_k = '0;
      end
    endcase
`ifdef JK_COUNTER_REG_SAT_EN
    if (w_at_limit) begin
      w_j = '0;
      w_k = '0;
    end
`endif
  end

  // Mirror of the cell update, used only to detect a change of q.
  assign w_q_next = (w_j & ~w_q) | (~w_k & w_q);

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_cell
      jk_cell u_cell (
        .clk     (clk),
        .rst     (rst),
        .rst_val (RST_VAL[gi]),
        .en      (en),
        .j       (w_j[gi]),
        .k       (w_k[gi]),
        .q       (w_q[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tc  <= 1'b0;
      r_chg <= 1'b0;
    end else begin
      r_tc  <= en & w_at_limit;
      r_chg <= en & (w_q_next != w_q);
    end
  end

  assign q   = w_q;
  assign tc  = r_tc;
  assign chg = r_chg;

endmodule

// File: tb/tb_jk_counter_reg.sv
// tb/tb_jk_counter_reg.sv - directed self-checking bench for jk_counter_reg (WIDTH=4)
module tb_jk_counter_reg;
  import jk_pkg::*;

  logic       clk;
  logic       rst;
  logic       en;
  logic [1:0] mode;
  logic [3:0] j;
  logic [3:0] k;
  logic [3:0] d;
  logic [3:0] q;
  logic       tc;
  logic       chg;

  int errors = 0;
  int checks = 0;
  int tc_seen;

  jk_counter_reg #(.WIDTH(4), .RST_VAL(4'h5)) dut (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .mode (mode),
    .j    (j),
    .k    (k),
    .d    (d),
    .q    (q),
    .tc   (tc),
    .chg  (chg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_out(input string tag, input logic [3:0] eq, input logic etc, input logic echg);
    check({tag, ".q"}, 32'(q), 32'(eq));
    check({tag, ".tc"}, 32'(tc), 32'(etc));
    check({tag, ".chg"}, 32'(chg), 32'(echg));
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; mode = MODE_JK; j = '0; k = '0; d = '0;
    #12;
    check_out("reset", 4'h5, 1'b0, 1'b0);

    @(negedge clk);
    rst = 1'b0; en = 1'b1; mode = MODE_LOAD; d = 4'h9;
    step();
    check_out("load9", 4'h9, 1'b0, 1'b1);
    mode = MODE_UP;
    step();
    check_out("up_a", 4'hA, 1'b0, 1'b1);

    // asynchronous reset between edges, mid-count
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check_out("async_rst", 4'h5, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    mode = MODE_JK; j = 4'b1100; k = 4'b1010;
    step();
    check_out("jk_mix", 4'b1101, 1'b0, 1'b1);
    j = 4'b0000; k = 4'b0000;
    step();
    check_out("jk_hold", 4'b1101, 1'b0, 1'b0);
    j = 4'b1111; k = 4'b1111;
    step();
    check_out("jk_tgl", 4'b0010, 1'b0, 1'b1);

    mode = MODE_LOAD; d = 4'hE;
    step();
    check_out("loadE", 4'hE, 1'b0, 1'b1);

`ifdef JK_COUNTER_REG_SAT_EN
    mode = MODE_UP;
    step();
    check_out("sat_up1", 4'hF, 1'b0, 1'b1);
    step();
    check_out("sat_up2", 4'hF, 1'b1, 1'b0);
    step();
    check_out("sat_up3", 4'hF, 1'b1, 1'b0);
    mode = MODE_LOAD; d = 4'h1;
    step();
    mode = MODE_DOWN;
    step();
    check_out("sat_dn1", 4'h0, 1'b0, 1'b1);
    step();
    check_out("sat_dn2", 4'h0, 1'b1, 1'b0);
`else
    mode = MODE_UP;
    step();
    check_out("up_f", 4'hF, 1'b0, 1'b1);
    step();
    check_out("up_wrap", 4'h0, 1'b1, 1'b1);
    step();
    check_out("up_after", 4'h1, 1'b0, 1'b1);

    tc_seen = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      if (tc === 1'b1) tc_seen++;
    end
    check("sustained_tc", 32'(tc_seen), 32'd1);
    check("sustained_q", 32'(q), 32'h1);

    mode = MODE_DOWN;
    step();
    check_out("dn_0", 4'h0, 1'b0, 1'b1);
    step();
    check_out("dn_wrap", 4'hF, 1'b1, 1'b1);
    en = 1'b0;
    step();
    check_out("en_off", 4'hF, 1'b0, 1'b0);
    en = 1'b1;
`endif

    // reset held across what would be the wrap edge
    mode = MODE_LOAD; d = 4'hF;
    step();
    mode = MODE_UP;
    rst = 1'b1;
    step();
    check_out("rst_wrap", 4'h5, 1'b0, 1'b0);
    rst = 1'b0;
    step();
    check_out("post_rst_up", 4'h6, 1'b0, 1'b1);

    mode = MODE_LOAD; d = 4'h6;
    step();
    check_out("load_same", 4'h6, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
